// File: rtl/rgb2ycbcr_pkg.sv
// rtl/rgb2ycbcr_pkg.sv - shared types, defaults and width helper for the rgb2ycbcr arbiter
package rgb2ycbcr_pkg;

  typedef logic owner_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam int DEFAULT_LATENCY = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rgb2ycbcr_arbiter_if.sv
// rtl/rgb2ycbcr_arbiter_if.sv - pixel requester valid/ready bundle (master = requester, slave = arbiter)
interface rgb2ycbcr_arbiter_if #(
  parameter int BIT_WIDTH = 8,
  parameter int V_BITW    = 9,
  parameter int H_BITW    = 10,
  parameter int A_BITW    = 21
);
  logic                 valid;
  logic                 ready;
  logic [BIT_WIDTH-1:0] r;
  logic [BIT_WIDTH-1:0] g;
  logic [BIT_WIDTH-1:0] b;
  logic [V_BITW-1:0]    vcnt;
  logic [H_BITW-1:0]    hcnt;
  logic [A_BITW-1:0]    addr;

  modport master (output valid, r, g, b, vcnt, hcnt, addr, input ready);
  modport slave  (input valid, r, g, b, vcnt, hcnt, addr, output ready);
endinterface

// File: rtl/rgb2ycbcr_tag_pipe.sv
// rtl/rgb2ycbcr_tag_pipe.sv - {valid, owner} delay line that follows beats through the converter
module rgb2ycbcr_tag_pipe
  import rgb2ycbcr_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LATENCY + 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push_valid,
  input  owner_t push_owner,
  output logic   tail_valid,
  output owner_t tail_owner
);

  tag_t [DEPTH-1:0] pipe;
  tag_t             head;

  assign head = {push_valid, push_owner};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], head};
    end
  end

  assign tail_valid = pipe[DEPTH-1].valid;
  assign tail_owner = pipe[DEPTH-1].owner;

endmodule

// File: rtl/rgb2ycbcr_arbiter.sv
// rtl/rgb2ycbcr_arbiter.sv - burst-locking two-requester arbiter in front of a shared rgb2ycbcr converter
// RGB2YCBCR_ARB_RR_EN: round-robin tie-break in IDLE; undefined gives fixed priority to requester 0.
module rgb2ycbcr_arbiter
  import rgb2ycbcr_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int LATENCY      = DEFAULT_LATENCY,
  parameter int MAX_BURST    = 16,
  localparam int V_BITW = clog2(FRAME_HEIGHT),
  localparam int H_BITW = clog2(FRAME_WIDTH),
  localparam int P_BITW = clog2(FRAME_HEIGHT * FRAME_WIDTH),
  localparam int A_BITW = P_BITW + 2
) (
  input  logic                 clock,
  input  logic                 reset,
  rgb2ycbcr_arbiter_if.slave   req0,
  rgb2ycbcr_arbiter_if.slave   req1,
  output logic [BIT_WIDTH-1:0] conv_r,
  output logic [BIT_WIDTH-1:0] conv_g,
  output logic [BIT_WIDTH-1:0] conv_b,
  output logic [V_BITW-1:0]    conv_vcnt,
  output logic [H_BITW-1:0]    conv_hcnt,
  output logic [A_BITW-1:0]    conv_addr,
  input  logic [BIT_WIDTH-1:0] conv_y,
  input  logic [BIT_WIDTH-1:0] conv_cb,
  input  logic [BIT_WIDTH-1:0] conv_cr,
  input  logic [V_BITW-1:0]    conv_out_vcnt,
  input  logic [H_BITW-1:0]    conv_out_hcnt,
  input  logic [A_BITW-1:0]    conv_out_addr,
  output logic                 out0_valid,
  output logic                 out1_valid,
  output logic [BIT_WIDTH-1:0] out_y,
  output logic [BIT_WIDTH-1:0] out_cb,
  output logic [BIT_WIDTH-1:0] out_cr,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic [A_BITW-1:0]    out_addr
);

  localparam int             CNT_W     = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state, state_n, tie_winner;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ready0, ready1, xfer0, xfer1;
  logic             tail_valid;
  owner_t           tail_owner;

  assign ready0 = (state == OWN0) && (cnt < BURST_MAX);
  assign ready1 = (state == OWN1) && (cnt < BURST_MAX);
  assign req0.ready = ready0;
  assign req1.ready = ready1;
  assign xfer0 = req0.valid && ready0;
  assign xfer1 = req1.valid && ready1;

`ifdef RGB2YCBCR_ARB_RR_EN
  // Resets to 1 so requester 0 takes the first simultaneous request.
  owner_t last_owner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state == IDLE && state_n == OWN0) begin
      last_owner <= 1'b0;
    end else if (state == IDLE && state_n == OWN1) begin
      last_owner <= 1'b1;
    end
  end

  assign tie_winner = (last_owner == 1'b1) ? OWN0 : OWN1;
`else
  assign tie_winner = OWN0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req0.valid && req1.valid) state_n = tie_winner;
        else if (req0.valid)          state_n = OWN0;
        else if (req1.valid)          state_n = OWN1;
      end
      OWN0: begin
        if (!req0.valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (ready0) begin
          if (cnt == LAST_BEAT) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      OWN1: begin
        if (!req1.valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (ready1) begin
          if (cnt == LAST_BEAT) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // conv_* holds its last beat between transfers; the tag pipe marks those cycles invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conv_r    <= '0;
      conv_g    <= '0;
      conv_b    <= '0;
      conv_vcnt <= '0;
      conv_hcnt <= '0;
      conv_addr <= '0;
    end else if (xfer0) begin
      conv_r    <= req0.r;
      conv_g    <= req0.g;
      conv_b    <= req0.b;
      conv_vcnt <= req0.vcnt;
      conv_hcnt <= req0.hcnt;
      conv_addr <= req0.addr;
    end else if (xfer1) begin
      conv_r    <= req1.r;
      conv_g    <= req1.g;
      conv_b    <= req1.b;
      conv_vcnt <= req1.vcnt;
      conv_hcnt <= req1.hcnt;
      conv_addr <= req1.addr;
    end
  end

  rgb2ycbcr_tag_pipe #(
    .DEPTH(LATENCY + 1)
  ) u_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .push_valid(xfer0 || xfer1),
    .push_owner(xfer1),
    .tail_valid(tail_valid),
    .tail_owner(tail_owner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out_y      <= '0;
      out_cb     <= '0;
      out_cr     <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
      out_addr   <= '0;
    end else begin
      out0_valid <= tail_valid && (tail_owner == 1'b0);
      out1_valid <= tail_valid && (tail_owner == 1'b1);
      if (tail_valid) begin
        out_y    <= conv_y;
        out_cb   <= conv_cb;
        out_cr   <= conv_cr;
        out_vcnt <= conv_out_vcnt;
        out_hcnt <= conv_out_hcnt;
        out_addr <= conv_out_addr;
      end
    end
  end

endmodule
